// File: rtl/fetch_hazard_ctrl_pkg.sv
// fetch_hazard_ctrl_pkg: shared state encoding, IF/ID field positions and width defaults.
package fetch_hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int PC_W_DEF = 11;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/fetch_hazard_ctrl_load_use.sv
// load_use_detect: flags a consumer in IF/ID of a load still in ID/EX (r0 never hazards).
module load_use_detect
    import fetch_hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        mem_read,
    input  logic [4:0]  id_ex_rt,
    output logic        lu
);
    logic [4:0] rs;
    logic [4:0] rt;
    always_comb begin
        rs = instr[RS_HI:RS_LO];
        rt = instr[RT_HI:RT_LO];
        lu = mem_read && (id_ex_rt != 5'd0) && ((id_ex_rt == rs) || (id_ex_rt == rt));
    end
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: PC/IF-ID stall and flush control for load-use hazards and branch redirects.
// Define FETCH_HAZARD_CNT_EN to build the saturating stall/flush debug counters.
module fetch_hazard_ctrl
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      if_id_instruccion,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic             PCSrc,
    output logic [PC_W-1:0]  pc_salto,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic [1:0]       state_debug,
    output logic [CNT_W-1:0] stall_cnt_debug,
    output logic [CNT_W-1:0] flush_cnt_debug
);
    state_e state_q;
    state_e state_d;
    logic   lu;
    logic   active;
    logic   stall;
    logic   redirect;

    load_use_detect u_lu (
        .instr    (if_id_instruccion),
        .mem_read (id_ex_mem_read),
        .id_ex_rt (id_ex_rt),
        .lu       (lu)
    );

    // Reset gating keeps the held-in-reset values independent of the clock.
    always_comb begin
        active      = (state_q == ST_RUN) || (state_q == ST_STALL);
        stall       = active && lu;
        redirect    = active && !lu && branch_taken;
        state_d     = (state_q == ST_INIT || state_q == ST_FLUSH) ? ST_RUN :
                      stall ? ST_STALL : redirect ? ST_FLUSH : ST_RUN;
        PCWrite     = reset_n && !stall;
        IF_ID_Write = reset_n && !stall;
        IF_Flush    = !reset_n || state_q == ST_INIT || state_q == ST_FLUSH || redirect;
        PCSrc       = reset_n && redirect;
        pc_salto    = branch_target;
        state_debug = state_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_INIT;
        else          state_q <= state_d;
    end

`ifdef FETCH_HAZARD_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    always_comb begin
        stall_cnt_d     = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d     = (redirect && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        stall_cnt_debug = stall_cnt_q;
        flush_cnt_debug = flush_cnt_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`else
    assign stall_cnt_debug = '0;
    assign flush_cnt_debug = '0;
`endif
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb_fetch_hazard_ctrl: directed checks of stall, flush, priority, reset and counter saturation.
module tb_fetch_hazard_ctrl;
`ifdef FETCH_HAZARD_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] if_id_instruccion = '0;
    logic        id_ex_mem_read = 1'b0;
    logic [4:0]  id_ex_rt = '0;
    logic        branch_taken = 1'b0;
    logic [10:0] branch_target = '0;
    logic        PCSrc, PCWrite, IF_ID_Write, IF_Flush;
    logic [10:0] pc_salto;
    logic [1:0]  state_debug;
    logic [7:0]  stall_cnt_debug, flush_cnt_debug;
    int tests = 0;
    int fails = 0;

    fetch_hazard_ctrl dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .if_id_instruccion (if_id_instruccion),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_rt          (id_ex_rt),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .PCSrc             (PCSrc),
        .pc_salto          (pc_salto),
        .PCWrite           (PCWrite),
        .IF_ID_Write       (IF_ID_Write),
        .IF_Flush          (IF_Flush),
        .state_debug       (state_debug),
        .stall_cnt_debug   (stall_cnt_debug),
        .flush_cnt_debug   (flush_cnt_debug)
    );

    always #5 clock = ~clock;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] rtf, input bit bt, input logic [10:0] tgt);
        @(negedge clock);
        id_ex_mem_read    = mr;
        id_ex_rt          = rt;
        if_id_instruccion = {6'd0, rs, rtf, 16'h0};
        branch_taken      = bt;
        branch_target     = tgt;
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++; if ({PCWrite, IF_ID_Write, IF_Flush, PCSrc} !== 4'b0010) begin fails++; $display("FAIL reset_ctl: got %b want 0010", {PCWrite, IF_ID_Write, IF_Flush, PCSrc}); end
        tests++; if (state_debug !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_debug); end
        tests++; if ({stall_cnt_debug, flush_cnt_debug} !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0000", {stall_cnt_debug, flush_cnt_debug}); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        tests++; if ({state_debug, IF_Flush, PCWrite, IF_ID_Write, PCSrc} !== 5'b00_1110) begin fails++; $display("FAIL init_cycle: got %b want 001110", {state_debug, IF_Flush, PCWrite, IF_ID_Write, PCSrc}); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if ({state_debug, IF_Flush, PCWrite} !== 4'b0101) begin fails++; $display("FAIL run_entry: got %b want 0101", {state_debug, IF_Flush, PCWrite}); end
    endtask

    task automatic test_stall();
        drive(1, 5, 5, 0, 0, 0);
        tests++; if ({state_debug, PCWrite, IF_ID_Write, IF_Flush, PCSrc} !== 6'b01_0000) begin fails++; $display("FAIL lu_rs_stall: got %b want 010000", {state_debug, PCWrite, IF_ID_Write, IF_Flush, PCSrc}); end
        drive(0, 5, 5, 0, 0, 0);
        tests++; if ({state_debug, PCWrite, IF_ID_Write} !== 4'b1011) begin fails++; $display("FAIL stall_release: got %b want 1011", {state_debug, PCWrite, IF_ID_Write}); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (state_debug !== 2'd1) begin fails++; $display("FAIL back_to_run: got %0d want 1", state_debug); end
        tests++; if (stall_cnt_debug !== (CNT ? 8'd1 : 8'd0)) begin fails++; $display("FAIL stall_cnt1: got %0d want %0d", stall_cnt_debug, CNT ? 1 : 0); end
        drive(1, 7, 3, 7, 0, 0);
        tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL lu_rt_stall: got %b want 0", PCWrite); end
        drive(1, 7, 3, 4, 0, 0);
        tests++; if ({state_debug, PCWrite} !== 3'b101) begin fails++; $display("FAIL no_match: got %b want 101", {state_debug, PCWrite}); end
    endtask

    task automatic test_r0_no_stall();
        drive(1, 0, 0, 0, 0, 0);
        tests++; if ({state_debug, PCWrite, IF_ID_Write} !== 4'b0111) begin fails++; $display("FAIL r0_no_stall: got %b want 0111", {state_debug, PCWrite, IF_ID_Write}); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (state_debug !== 2'd1) begin fails++; $display("FAIL r0_state: got %0d want 1", state_debug); end
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 0, 1, 11'h1A4);
        tests++; if ({PCSrc, IF_Flush, PCWrite, IF_ID_Write} !== 4'b1111) begin fails++; $display("FAIL br_ctl: got %b want 1111", {PCSrc, IF_Flush, PCWrite, IF_ID_Write}); end
        tests++; if (pc_salto !== 11'h1A4) begin fails++; $display("FAIL br_target: got %h want 1a4", pc_salto); end
        drive(0, 0, 0, 0, 1, 11'h055);
        tests++; if ({state_debug, PCSrc, IF_Flush, PCWrite} !== 5'b11_011) begin fails++; $display("FAIL br_flush: got %b want 11011", {state_debug, PCSrc, IF_Flush, PCWrite}); end
        tests++; if (pc_salto !== 11'h055) begin fails++; $display("FAIL salto_comb: got %h want 055", pc_salto); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if ({state_debug, IF_Flush, PCSrc} !== 4'b0100) begin fails++; $display("FAIL br_done: got %b want 0100", {state_debug, IF_Flush, PCSrc}); end
        tests++; if (flush_cnt_debug !== (CNT ? 8'd1 : 8'd0)) begin fails++; $display("FAIL flush_cnt1: got %0d want %0d", flush_cnt_debug, CNT ? 1 : 0); end
    endtask

    task automatic test_lu_and_branch();
        drive(1, 5, 5, 0, 1, 11'h002);
        tests++; if ({PCSrc, PCWrite, IF_Flush} !== 3'b000) begin fails++; $display("FAIL prio_stall: got %b want 000", {PCSrc, PCWrite, IF_Flush}); end
        drive(0, 5, 5, 0, 1, 11'h002);
        tests++; if ({state_debug, PCSrc, IF_Flush, pc_salto} !== {2'd2, 2'b11, 11'h002}) begin fails++; $display("FAIL prio_redirect: got %b want 1011", {state_debug, PCSrc, IF_Flush}); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if ({state_debug, IF_Flush} !== 3'b111) begin fails++; $display("FAIL prio_flush: got %b want 111", {state_debug, IF_Flush}); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if ({stall_cnt_debug, flush_cnt_debug} !== (CNT ? {8'd3, 8'd2} : 16'h0)) begin fails++; $display("FAIL cnt_after_prio: got %h want %h", {stall_cnt_debug, flush_cnt_debug}, CNT ? 16'h0302 : 16'h0); end
    endtask

    task automatic test_reset_in_flush();
        drive(0, 0, 0, 0, 1, 11'h100);
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (state_debug !== 2'd3) begin fails++; $display("FAIL pre_reset_flush: got %0d want 3", state_debug); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if ({state_debug, PCWrite, IF_ID_Write, IF_Flush, PCSrc} !== 6'b00_0010) begin fails++; $display("FAIL async_reset: got %b want 000010", {state_debug, PCWrite, IF_ID_Write, IF_Flush, PCSrc}); end
        tests++; if ({stall_cnt_debug, flush_cnt_debug} !== 16'h0) begin fails++; $display("FAIL async_cnt: got %h want 0000", {stall_cnt_debug, flush_cnt_debug}); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        tests++; if ({state_debug, IF_Flush, PCWrite} !== 4'b0011) begin fails++; $display("FAIL rerelease_init: got %b want 0011", {state_debug, IF_Flush, PCWrite}); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (state_debug !== 2'd1) begin fails++; $display("FAIL rerelease_run: got %0d want 1", state_debug); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) drive(1, 9, 9, 0, 0, 0);
        tests++; if ({state_debug, PCWrite} !== 3'b100) begin fails++; $display("FAIL hold_stall: got %b want 100", {state_debug, PCWrite}); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (stall_cnt_debug !== (CNT ? 8'd255 : 8'd0)) begin fails++; $display("FAIL stall_sat: got %0d want %0d", stall_cnt_debug, CNT ? 255 : 0); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_r0_no_stall();
        test_branch();
        test_lu_and_branch();
        test_reset_in_flush();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_hazard_ctrl.md
FETCH_HAZARD_CTRL -- requirements
Module: fetch_hazard_ctrl

Interface
REQ-001 Parameter PC_W, default 11, SHALL set the width of the PC and branch-target ports.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the debug event counters.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 if_id_instruccion  in  32  instruction held in the IF/ID register; rs=[25:21], rt=[20:16].
REQ-006 id_ex_mem_read  in  1  the instruction in ID/EX is a load.
REQ-007 id_ex_rt  in  5  destination register of that load.
REQ-008 branch_taken  in  1  branch/jump resolved taken in ID this cycle.
REQ-009 branch_target  in  PC_W  resolved target address.
REQ-010 PCSrc  out  1  selects pc_salto as the next PC.
REQ-011 pc_salto  out  PC_W  redirect address.
REQ-012 PCWrite  out  1  PC load enable.
REQ-013 IF_ID_Write  out  1  IF/ID load enable.
REQ-014 IF_Flush  out  1  loads a bubble (all-zero instruction) into IF/ID.
REQ-015 state_debug  out  2  current FSM state encoding.
REQ-016 stall_cnt_debug, flush_cnt_debug  out  CNT_W each  event counters (see Configuration).

Function
REQ-017 Load-use hazard (lu) SHALL be the combinational term id_ex_mem_read AND id_ex_rt!=0 AND (id_ex_rt==rs OR id_ex_rt==rt).
REQ-018 FSM states SHALL be INIT=0, RUN=1, STALL=2, FLUSH=3.
REQ-019 INIT SHALL drive PCWrite=1, IF_ID_Write=1, IF_Flush=1, PCSrc=0, and SHALL go to RUN unconditionally after one cycle.
REQ-020 RUN with lu=1 SHALL drive PCWrite=0, IF_ID_Write=0, IF_Flush=0, PCSrc=0, and SHALL go to STALL.
REQ-021 RUN with lu=0 and branch_taken=1 SHALL drive PCSrc=1, pc_salto=branch_target, PCWrite=1, IF_ID_Write=1, IF_Flush=1, and SHALL go to FLUSH.
REQ-022 RUN with lu=0 and branch_taken=0 SHALL drive PCWrite=1, IF_ID_Write=1, IF_Flush=0, PCSrc=0, and SHALL remain in RUN.
REQ-023 STALL SHALL apply the RUN rules (REQ-020..022), so a still-asserted lu holds STALL and a branch is evaluated once lu clears.
REQ-024 FLUSH SHALL drive PCWrite=1, IF_ID_Write=1, IF_Flush=1, PCSrc=0, SHALL ignore branch_taken and lu, and SHALL return to RUN; this covers the one-cycle stale output of the synchronous instruction memory.
REQ-025 Simultaneous lu and branch_taken SHALL give the stall priority; the branch SHALL NOT redirect until lu=0.
REQ-026 pc_salto SHALL equal branch_target combinationally in every state; it is meaningful only when PCSrc=1.
REQ-027 Control outputs SHALL be combinational from the state and inputs, with no added latency; redirect-to-correct-fetch latency SHALL be 2 cycles.

Reset
REQ-028 While reset_n=0: state=INIT, PCWrite=0, IF_ID_Write=0, IF_Flush=1, PCSrc=0, counters=0, state_debug=0.
REQ-029 Assertion mid-operation SHALL abort any STALL or FLUSH immediately; release SHALL always pass through exactly one INIT cycle.

Configuration
REQ-030 Macro FETCH_HAZARD_CNT_EN SHALL compile the counters in.
REQ-031 With FETCH_HAZARD_CNT_EN, stall_cnt_debug SHALL increment on each cycle with lu=1 in RUN/STALL, flush_cnt_debug SHALL increment on each branch redirect, and both SHALL saturate at 2^CNT_W-1.
REQ-032 Without FETCH_HAZARD_CNT_EN, both counter outputs SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-033 A shared package SHALL hold the state encoding, the rs/rt field bit positions, and the PC_W default.
REQ-034 Sub-module load_use_detect SHALL be the only sub-module; it implements REQ-017 combinationally.

Verification
REQ-035 Release reset: 1 cycle with IF_Flush=1 and PCWrite=1, state 0->1, then IF_Flush=0.
REQ-036 id_ex_mem_read=1, id_ex_rt=5, rs=5: PCWrite=0 and IF_ID_Write=0 for exactly that cycle; mem_read=0 next cycle -> RUN, stall_cnt_debug=1.
REQ-037 id_ex_rt=0 with rs=0 and mem_read=1: no stall.
REQ-038 branch_taken=1, target=0x1A4: PCSrc=1, pc_salto=0x1A4, IF_Flush=1 for 2 consecutive cycles; a branch_taken pulse in the 2nd cycle is ignored; flush_cnt_debug=1.
REQ-039 lu and branch_taken both asserted: 1 stall cycle, then redirect the following cycle.
REQ-040 reset_n low while in FLUSH: outputs take REQ-028 values asynchronously; 300 stall events -> stall_cnt_debug=255.
